// File: rtl/cpu_state_dumper_if.sv
// Byte stream channel from the state dumper to a UART or display back end.
// A byte moves on a clock edge where out_valid and out_ready are both high.
interface cpu_state_dumper_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;

  modport master (output out_valid, output out_byte, input out_ready);
  modport slave  (input out_valid, input out_byte, output out_ready);
endinterface

// File: rtl/cpu_state_dumper.sv
// CPU state dumper: snapshots PC/INST, sweeps the 32 general registers and a
// window of data memory through the CPU debug port, and streams a framed,
// XOR-checksummed byte sequence:
//   HEADER, PC, INST, R0..R31, MEM[0..NUM_MEM-1], CSUM
// Every word goes out MSB first. Registers and memory are read live; the CPU
// must be stopped for the dump to be coherent.
module cpu_state_dumper #(
  parameter int unsigned NUM_MEM  = 32,
  parameter logic [31:0] MEM_BASE = 32'd0,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  cpu_state_dumper_if.master out_if
);

  // Word index layout: 0 = PC, 1 = INST, 2..33 = registers, 34.. = memory.
  localparam logic [6:0] FIRST_REG_W = 7'd2;
  localparam logic [6:0] FIRST_MEM_W = 7'd34;
  localparam logic [6:0] LAST_W      = 7'(33 + NUM_MEM);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_SEND, S_CSUM, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic [7:0]  byte_q, byte_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [23:0] rest_q, rest_d;   // bytes of the current word not yet presented
  logic [7:0]  csum_q, csum_d;
  logic [6:0]  w_q, w_d;
  logic [1:0]  cnt_q, cnt_d;     // bytes of the current word already transferred
  logic [31:0] word_s;
  logic        xfer_s;

  assign xfer_s = valid_q & out_if.out_ready;

  // Select the word being captured for the current index.
  always_comb begin
    if (w_q == 7'd0) begin
      word_s = pc_q;
    end else if (w_q == 7'd1) begin
      word_s = inst_q;
    end else if (w_q < FIRST_MEM_W) begin
      word_s = rf_data;
    end else begin
      word_s = mem_data;
    end
  end

  // Next-state and next-output logic of the dump sequencer.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    byte_d     = byte_q;
    rf_addr_d  = rf_addr_q;
    mem_addr_d = mem_addr_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    rest_d     = rest_q;
    csum_d     = csum_q;
    w_d        = w_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          busy_d  = 1'b1;
          pc_d    = cpu_pc;
          inst_d  = cpu_inst;
          csum_d  = 8'd0;
          w_d     = 7'd0;
          cnt_d   = 2'd0;
          valid_d = 1'b1;
          byte_d  = HEADER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (xfer_s) begin
          state_d = S_LOAD;
          valid_d = 1'b0;
        end else begin
          state_d = S_HDR;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
        byte_d  = word_s[31:24];
        rest_d  = word_s[23:0];
        valid_d = 1'b1;
        cnt_d   = 2'd0;
      end
      S_SEND: begin
        if (xfer_s) begin
          csum_d = csum_q ^ byte_q;
          byte_d = rest_q[23:16];
          rest_d = {rest_q[15:0], 8'd0};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (w_q == LAST_W) begin
              state_d = S_CSUM;
              byte_d  = csum_q ^ byte_q;
            end else begin
              state_d = S_LOAD;
              valid_d = 1'b0;
              w_d     = w_q + 7'd1;
              // Present the debug address one cycle ahead of the capture.
              if ((w_d >= FIRST_REG_W) && (w_d < FIRST_MEM_W)) begin
                rf_addr_d = 5'(w_d - FIRST_REG_W);
              end else if (w_d >= FIRST_MEM_W) begin
                mem_addr_d = MEM_BASE + {23'd0, w_d - FIRST_MEM_W, 2'b00};
              end else begin
                rf_addr_d = rf_addr_q;
              end
            end
          end else begin
            state_d = S_SEND;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_CSUM: begin
        if (xfer_s) begin
          state_d = S_FIN;
          valid_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_CSUM;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      byte_q     <= 8'd0;
      rf_addr_q  <= 5'd0;
      mem_addr_q <= MEM_BASE;
      pc_q       <= 32'd0;
      inst_q     <= 32'd0;
      rest_q     <= 24'd0;
      csum_q     <= 8'd0;
      w_q        <= 7'd0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      byte_q     <= byte_d;
      rf_addr_q  <= rf_addr_d;
      mem_addr_q <= mem_addr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      rest_q     <= rest_d;
      csum_q     <= csum_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign rf_addr          = rf_addr_q;
  assign mem_addr         = mem_addr_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_byte  = byte_q;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Bench for cpu_state_dumper: a default instance (NUM_MEM=32, MEM_BASE=0) and
// a NUM_MEM=0, MEM_BASE=0x40 instance, both fed by a register/memory model.
// Expected frames come from a word-list reference model.
`timescale 1ns/1ps
module tb_cpu_state_dumper;

  localparam logic [31:0] BASE_B = 32'h40;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] mem_addr_a, mem_addr_b;
  logic [31:0] rf_data_a, rf_data_b, mem_data_a, mem_data_b;
  logic [31:0] cpu_pc = 32'd0, cpu_inst = 32'd0;
  logic [31:0] regs [32];
  logic [31:0] mem  [32];

  cpu_state_dumper_if if_a ();
  cpu_state_dumper_if if_b ();

  cpu_state_dumper u_dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .busy(busy_a), .done(done_a),
    .rf_addr(rf_addr_a), .rf_data(rf_data_a), .mem_addr(mem_addr_a),
    .mem_data(mem_data_a), .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .out_if(if_a)
  );

  cpu_state_dumper #(.NUM_MEM(0), .MEM_BASE(BASE_B), .HEADER(8'hA5)) u_dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .busy(busy_b), .done(done_b),
    .rf_addr(rf_addr_b), .rf_data(rf_data_b), .mem_addr(mem_addr_b),
    .mem_data(mem_data_b), .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .out_if(if_b)
  );

  // CPU debug port model: asynchronous reads
  assign rf_data_a  = regs[rf_addr_a];
  assign rf_data_b  = regs[rf_addr_b];
  assign mem_data_a = (mem_addr_a[31:7] == 25'd0) ? mem[mem_addr_a[6:2]] : 32'd0;
  assign mem_data_b = 32'hCAFE0000 ^ mem_addr_b;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_a[$], got_b[$];
  logic [4:0]  load_rf[$];
  logic [31:0] load_mem[$];
  int viol_a, viol_b, done_cnt_a, done_cnt_b, rf_chg, mem_chg, mem_b_moved;
  logic pv_a, pr_a, pv_b, pr_b;
  logic [7:0] pb_a, pb_b;
  logic [4:0] last_rf;
  logic [31:0] last_mem;

  // Reference frame: word list, then bytes MSB first, XOR checksum
  task automatic model_frame(input int nmem);
    logic [31:0] words[$];
    logic [31:0] wv;
    logic [7:0]  bt, cs;
    words.delete();
    exp_q.delete();
    words.push_back(cpu_pc);
    words.push_back(cpu_inst);
    for (int i = 0; i < 32; i++) words.push_back(regs[i]);
    for (int i = 0; i < nmem; i++) words.push_back(mem[i]);
    exp_q.push_back(8'hA5);
    cs = 8'd0;
    for (int i = 0; i < words.size(); i++) begin
      wv = words[i];
      for (int b = 3; b >= 0; b--) begin
        bt = 8'(wv >> (8 * b));
        exp_q.push_back(bt);
        cs = cs ^ bt;
      end
    end
    exp_q.push_back(cs);
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got_a.size()) return got_a[i];
    return 8'hxx;
  endfunction

  task automatic randomize_cpu();
    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom;
      mem[i]  = $urandom;
    end
    cpu_pc   = $urandom;
    cpu_inst = $urandom;
  endtask

  // Record one cycle of both stream ports (called at the falling edge)
  task automatic sample_cycle();
    if (pv_a && !pr_a && (!if_a.out_valid || if_a.out_byte !== pb_a)) viol_a++;
    if (pv_b && !pr_b && (!if_b.out_valid || if_b.out_byte !== pb_b)) viol_b++;
    if (if_a.out_valid && if_a.out_ready) got_a.push_back(if_a.out_byte);
    if (if_b.out_valid && if_b.out_ready) got_b.push_back(if_b.out_byte);
    if (busy_a && !if_a.out_valid) begin
      load_rf.push_back(rf_addr_a);
      load_mem.push_back(mem_addr_a);
    end
    if (rf_addr_a !== last_rf) rf_chg++;
    if (mem_addr_a !== last_mem) mem_chg++;
    last_rf  = rf_addr_a;
    last_mem = mem_addr_a;
    if (mem_addr_b !== BASE_B) mem_b_moved++;
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    pv_a = if_a.out_valid; pr_a = if_a.out_ready; pb_a = if_a.out_byte;
    pv_b = if_b.out_valid; pr_b = if_b.out_ready; pb_b = if_b.out_byte;
  endtask

  // Start one frame and run it to done (mode 1 = ~30% random ready);
  // x1..x3 are cycles in which start is pulsed again on instance A
  task automatic run_frame(input bit sel, input int mode, input int x1, input int x2,
                           input int x3, output int done_cyc, output int busy_gaps,
                           output logic busy_at_done);
    logic r;
    got_a.delete(); got_b.delete(); load_rf.delete(); load_mem.delete();
    viol_a = 0; viol_b = 0; done_cnt_a = 0; done_cnt_b = 0;
    rf_chg = 0; mem_chg = 0; mem_b_moved = 0;
    pv_a = 1'b0; pv_b = 1'b0; pr_a = 1'b0; pr_b = 1'b0; pb_a = 8'd0; pb_b = 8'd0;
    last_rf = rf_addr_a; last_mem = mem_addr_a;
    done_cyc = -1; busy_gaps = 0; busy_at_done = 1'bx;
    @(negedge clk);
    if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      r = (mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b1;
      if_a.out_ready = r; if_b.out_ready = r;
      start_a = (!sel && (cyc == x1 || cyc == x2 || cyc == x3));
      @(negedge clk);
      sample_cycle();
      if (sel ? done_b : done_a) begin
        done_cyc = cyc;
        busy_at_done = sel ? busy_b : busy_a;
        break;
      end
      if (!(sel ? busy_b : busy_a)) busy_gaps++;
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      @(negedge clk);
      sample_cycle();
    end
  endtask

  task automatic check_frame_a(input string name);
    int mism;
    mism = 0;
    total++;
    if (got_a.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s_len: got %0d bytes, want %0d", name, got_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++)
      if (got_at(i) !== exp_q[i]) mism++;
    total++;
    if (mism !== 0) begin
      bad++;
      $display("FAIL %s_bytes: %0d byte(s) differ, want 0", name, mism);
    end
  endtask

  task automatic test_reset();
    #23;
    total++;
    if ({busy_a, done_a, if_a.out_valid, if_a.out_byte, rf_addr_a} !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b byte=%h rf=%h, want all 0",
               busy_a, done_a, if_a.out_valid, if_a.out_byte, rf_addr_a);
    end
    total++;
    if (mem_addr_a !== 32'd0 || mem_addr_b !== BASE_B) begin
      bad++;
      $display("FAIL reset_mem_addr: got %h/%h, want 0/40", mem_addr_a, mem_addr_b);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || if_a.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", busy_a, if_a.out_valid);
    end
  endtask

  task automatic test_fixed_frame();
    int dc, gaps;
    logic bd;
    for (int i = 0; i < 32; i++) begin regs[i] = 32'd0; mem[i] = 32'd0; end
    regs[1] = 32'h12345678; regs[31] = 32'hFFFFFFFF; mem[0] = 32'hDEADBEEF;
    cpu_pc = 32'h0000001C; cpu_inst = 32'h24010005;
    model_frame(32);
    run_frame(1'b0, 0, 0, 0, 0, dc, gaps, bd);
    check_frame_a("fixed");
    total++;
    if (got_at(0) !== 8'hA5) begin bad++; $display("FAIL header: got %h want a5", got_at(0)); end
    total++;
    if ({got_at(1), got_at(2), got_at(3), got_at(4)} !== 32'h0000001C) begin
      bad++; $display("FAIL pc_bytes: got %h%h%h%h want 0000001c", got_at(1), got_at(2), got_at(3), got_at(4));
    end
    total++;
    if ({got_at(13), got_at(14), got_at(15), got_at(16)} !== 32'h12345678) begin
      bad++; $display("FAIL r1_bytes: got %h%h%h%h want 12345678", got_at(13), got_at(14), got_at(15), got_at(16));
    end
    total++;
    if ({got_at(137), got_at(138), got_at(139), got_at(140)} !== 32'hDEADBEEF) begin
      bad++; $display("FAIL mem0_bytes: got %h%h%h%h want deadbeef", got_at(137), got_at(138), got_at(139), got_at(140));
    end
    total++;
    if (got_at(265) !== exp_q[265]) begin
      bad++; $display("FAIL csum: got %h want %h", got_at(265), exp_q[265]);
    end
    total++;
    if (dc !== 333) begin bad++; $display("FAIL done_cycle: got %0d want 333", dc); end
    total++;
    if (bd !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL busy_after_done: got %b/%b want 0/0", bd, busy_a);
    end
    total++;
    if (gaps !== 0 || done_cnt_a !== 1) begin
      bad++; $display("FAIL busy_done_shape: got gaps=%0d dones=%0d want 0 1", gaps, done_cnt_a);
    end
  endtask

  task automatic test_backpressure();
    int dc, gaps;
    logic bd;
    run_frame(1'b0, 1, 0, 0, 0, dc, gaps, bd);
    check_frame_a("backpressure");
    total++;
    if (viol_a !== 0) begin bad++; $display("FAIL stall_stability: got %0d violations want 0", viol_a); end
    total++;
    if (dc <= 333 || done_cnt_a !== 1) begin
      bad++; $display("FAIL bp_done: got cycle %0d dones %0d, want >333 and 1", dc, done_cnt_a);
    end
  endtask

  task automatic test_back_to_back_start();
    int dc, gaps;
    logic bd;
    randomize_cpu();
    model_frame(32);
    run_frame(1'b0, 0, 5, 100, 332, dc, gaps, bd);
    check_frame_a("restart");
    total++;
    if (gaps !== 0 || dc !== 333 || done_cnt_a !== 1) begin
      bad++; $display("FAIL restart_ignored: got gaps=%0d done=%0d dones=%0d want 0 333 1", gaps, dc, done_cnt_a);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dc, gaps, mism;
    logic bd;
    logic [4:0] rf_before;
    randomize_cpu();
    @(negedge clk);
    if_a.out_ready = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (48) @(posedge clk);
    #2;
    rf_before = rf_addr_a;
    #1;
    resetn = 1'b0;
    #1;
    total++;
    if (rf_before !== 5'd7) begin bad++; $display("FAIL rf_addr_mid: got %0d want 7", rf_before); end
    total++;
    if ({if_a.out_valid, busy_a, rf_addr_a, if_a.out_byte} !== 15'd0) begin
      bad++; $display("FAIL async_reset: got valid=%b busy=%b rf=%h byte=%h want all 0",
                      if_a.out_valid, busy_a, rf_addr_a, if_a.out_byte);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_frame(32);
    run_frame(1'b0, 0, 0, 0, 0, dc, gaps, bd);
    check_frame_a("after_reset");
    mism = 0;
    if (load_rf.size() !== 66) mism++;
    for (int k = 0; k < load_rf.size() && k < 66; k++) begin
      if (k >= 2 && k < 34 && load_rf[k] !== 5'(k - 2)) mism++;
      if (k >= 34 && load_mem[k] !== 32'(4 * (k - 34))) mism++;
    end
    total++;
    if (mism !== 0) begin bad++; $display("FAIL load_addresses: got %0d errors want 0", mism); end
    total++;
    if (rf_chg !== 31 || mem_chg !== 31) begin
      bad++; $display("FAIL addr_steps: got rf=%0d mem=%0d changes want 31 31", rf_chg, mem_chg);
    end
  endtask

  task automatic test_no_mem();
    int dc, gaps, mism;
    logic bd;
    randomize_cpu();
    model_frame(0);
    run_frame(1'b1, 0, 0, 0, 0, dc, gaps, bd);
    total++;
    if (got_b.size() !== 138) begin bad++; $display("FAIL nomem_len: got %0d want 138", got_b.size()); end
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_b.size() || got_b[i] !== exp_q[i]) mism++;
    total++;
    if (mism !== 0) begin bad++; $display("FAIL nomem_bytes: got %0d differing want 0", mism); end
    total++;
    if (dc !== 173) begin bad++; $display("FAIL nomem_done: got %0d want 173", dc); end
    total++;
    if (mem_b_moved !== 0) begin bad++; $display("FAIL nomem_addr: got %0d moves want 0", mem_b_moved); end
  endtask

  initial begin
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin regs[i] = 32'd0; mem[i] = 32'd0; end
    test_reset();
    test_fixed_frame();
    test_backpressure();
    test_back_to_back_start();
    test_reset_mid_frame();
    test_no_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
